// File: rtl/frame_writer.sv
`default_nettype none
// frame_writer: rectangle-fill / screen-clear write engine for the 640x480x8 frame buffer.
// Rev 1.0 - initial release.
module frame_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cmd_sig,
  input  logic [31:0]       cmd_pos,
  input  logic [31:0]       cmd_size,
  input  logic [31:0]       cmd_ctrl,
  output logic [1:0]        sts_sig,
  output logic [ADDR_W-1:0] frame_wrAddress,
  output logic [DATA_W-1:0] frame_input,
  output logic              frame_we
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int              RB_W      = 21;
  localparam logic [10:0]     H_LIM     = 11'(H_RES);
  localparam logic [10:0]     V_LIM     = 11'(V_RES);
  localparam logic [RB_W-1:0] LINE_STEP = RB_W'(H_RES);

  state_t          state_q;
  logic [9:0]      x_q, y_q, w_q, h_q, col_q, row_q;
  logic [7:0]      colour_q;
  logic [1:0]      op_q;
  logic [RB_W-1:0] rowbase_q;

  logic [9:0]      col_d, row_d;
  logic [RB_W-1:0] rowbase_d, addr_d;
  logic [10:0]     px_d, py_d;
  logic            we_d, last_col, last_px;
  logic            unused_bits;

  assign unused_bits = ^{cmd_pos[31:26], cmd_pos[15:10], cmd_size[31:26],
                         cmd_size[15:10], cmd_ctrl[31:10]};

  // Outputs are registered one pixel ahead: SETUP loads pixel 0, DRAW loads the next one.
  always_comb begin
    last_col  = (col_q == w_q - 10'd1);
    last_px   = last_col && (row_q == h_q - 10'd1);
    col_d     = 10'd0;
    row_d     = 10'd0;
    rowbase_d = ({11'd0, y_q} << 9) + ({11'd0, y_q} << 7);
    if (state_q == DRAW) begin
      col_d     = last_col ? 10'd0 : col_q + 10'd1;
      row_d     = last_col ? row_q + 10'd1 : row_q;
      rowbase_d = last_col ? rowbase_q + LINE_STEP : rowbase_q;
    end
    px_d   = {1'b0, x_q} + {1'b0, col_d};
    py_d   = {1'b0, y_q} + {1'b0, row_d};
    we_d   = (px_d < H_LIM) && (py_d < V_LIM);
    addr_d = rowbase_d + {{(RB_W-11){1'b0}}, px_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      sts_sig         <= 2'b00;
      frame_we        <= 1'b0;
      frame_wrAddress <= '0;
      frame_input     <= '0;
      x_q             <= '0;
      y_q             <= '0;
      w_q             <= '0;
      h_q             <= '0;
      col_q           <= '0;
      row_q           <= '0;
      colour_q        <= '0;
      op_q            <= '0;
      rowbase_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_we <= 1'b0;
          if (cmd_sig == 2'b01) begin
            op_q     <= cmd_ctrl[9:8];
            colour_q <= cmd_ctrl[7:0];
            if (cmd_ctrl[9:8] == 2'b01) begin
              x_q <= '0;
              y_q <= '0;
              w_q <= 10'(H_RES);
              h_q <= 10'(V_RES);
            end else begin
              x_q <= cmd_pos[9:0];
              y_q <= cmd_pos[25:16];
              w_q <= cmd_size[9:0];
              h_q <= cmd_size[25:16];
            end
            state_q <= SETUP;
            sts_sig <= 2'b01;
          end
        end
        SETUP: begin
          if (w_q == 10'd0 || h_q == 10'd0 || op_q[1]) begin
            state_q  <= DONE;
            sts_sig  <= 2'b10;
            frame_we <= 1'b0;
          end else begin
            state_q         <= DRAW;
            col_q           <= col_d;
            row_q           <= row_d;
            rowbase_q       <= rowbase_d;
            frame_we        <= we_d;
            frame_wrAddress <= addr_d[ADDR_W-1:0];
            frame_input     <= DATA_W'(colour_q);
          end
        end
        DRAW: begin
          // The pixel already on the outputs is written at this edge, abort or not.
          if (last_px || cmd_sig == 2'b11) begin
            state_q  <= DONE;
            sts_sig  <= 2'b10;
            frame_we <= 1'b0;
          end else begin
            col_q           <= col_d;
            row_q           <= row_d;
            rowbase_q       <= rowbase_d;
            frame_we        <= we_d;
            frame_wrAddress <= addr_d[ADDR_W-1:0];
          end
        end
        DONE: begin
          frame_we <= 1'b0;
          if (cmd_sig[0] == 1'b0) begin
            state_q <= IDLE;
            sts_sig <= 2'b00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
